// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART printer arbiter: FSM state encodings,
// ASCII constants used by the optional line tag, and the round-robin
// search helper used by the picker.
// Optional feature macro: UART_ARB_LINE_TAG_EN (prefix each granted line
// with "[<owner>] ").
package uart_arb_pkg;

    // Widest requester vector the search helper handles (N is at most 10).
    localparam int MAX_REQ = 16;

    // FSM state encodings.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PFX0   = 3'd1;
    localparam logic [2:0] ST_PFX1   = 3'd2;
    localparam logic [2:0] ST_PFX2   = 3'd3;
    localparam logic [2:0] ST_PFX3   = 3'd4;
    localparam logic [2:0] ST_LOCKED = 3'd5;

    // ASCII characters that matter to the arbiter.
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_LBR  = 8'h5B;
    localparam logic [7:0] ASCII_RBR  = 8'h5D;
    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    // First set bit of valid strictly after index last, wrapping modulo n.
    // Returns last when nothing is valid (caller qualifies with any_valid).
    function automatic logic [3:0] rr_next(
        input logic [15:0] valid,
        input logic [3:0]  last,
        input logic [4:0]  n
    );
        logic [3:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= int'(n)) begin
                idx = (int'(last) + k) % int'(n);
                if (!found && valid[idx[3:0]]) begin
                    pick  = idx[3:0];
                    found = 1'b1;
                end else begin
                    found = found;
                end
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: given the pending requests and the
// previous grantee, selects the next requester to own the printer sink.
module uart_rr_picker #(
    parameter int N  = 4,
    parameter int OW = 2
) (
    input  logic [N-1:0]  req_valid,
    input  logic [OW-1:0] owner,
    output logic [OW-1:0] pick,
    output logic          any_valid
);
    import uart_arb_pkg::*;

    logic [15:0] valid_ext_s;
    logic [3:0]  last_ext_s;
    logic [3:0]  pick_ext_s;

    // Widen inputs to the helper's fixed width and search after the last owner.
    always_comb begin
        valid_ext_s          = 16'h0000;
        valid_ext_s[N-1:0]   = req_valid;
        last_ext_s           = 4'h0;
        last_ext_s[OW-1:0]   = owner;
        pick_ext_s           = rr_next(valid_ext_s, last_ext_s, 5'(N));
        pick                 = pick_ext_s[OW-1:0];
        any_valid            = |req_valid;
    end

endmodule

// File: rtl/uart_print_arbiter.sv
// Shares one simulation UART printer sink between N requesters. A grantee
// owns the sink for a whole line and is released on newline, on reaching
// MAX_LINE accepted characters, or after TIMEOUT idle cycles, so lines from
// different requesters never interleave in the log.
// Optional feature macro: UART_ARB_LINE_TAG_EN -- each grant first emits
// "[<owner>] " through PFX0..PFX3 before the owner's characters flow.
module uart_print_arbiter #(
    parameter int N        = 4,
    parameter int TIMEOUT  = 256,
    parameter int MAX_LINE = 128,
    localparam int OW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [8*N-1:0]  req_data,
    input  logic [32*N-1:0] req_addr,
    output logic            out_valid,
    output logic [7:0]      out_data,
    output logic [31:0]     out_addr,
    output logic [OW-1:0]   owner,
    output logic            busy
);
    import uart_arb_pkg::*;

    localparam int CW = $clog2(MAX_LINE + 1);
    localparam int IW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CHAR_MAX  = CW'(MAX_LINE);
    localparam logic [CW-1:0] CHAR_LAST = CW'(MAX_LINE - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    // Registered state
    logic [2:0]    state_r;
    logic [OW-1:0] owner_r;
    logic [CW-1:0] char_cnt_r;
    logic [IW-1:0] idle_cnt_r;
    logic          out_valid_r;
    logic [7:0]    out_data_r;
    logic [31:0]   out_addr_r;

    // Next-state values
    logic [2:0]    state_nxt_s;
    logic [OW-1:0] owner_nxt_s;
    logic [CW-1:0] char_cnt_nxt_s;
    logic [IW-1:0] idle_cnt_nxt_s;
    logic          out_valid_nxt_s;
    logic [7:0]    out_data_nxt_s;

    // Owner's request lane and derived conditions
    logic          sel_valid_s;
    logic [7:0]    sel_data_s;
    logic [31:0]   sel_addr_s;
    logic          xfer_s;
    logic          lf_hit_s;
    logic          cap_hit_s;
    logic          idle_hit_s;
    logic          pfx_valid_s;
    logic [7:0]    pfx_data_s;
    logic [OW-1:0] pick_s;
    logic          any_valid_s;

    uart_rr_picker #(
        .N  (N),
        .OW (OW)
    ) u_picker (
        .req_valid (req_valid),
        .owner     (owner_r),
        .pick      (pick_s),
        .any_valid (any_valid_s)
    );

    // Mux out the current owner's valid/data/addr lane.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_data_s  = 8'h00;
        sel_addr_s  = 32'h0000_0000;
        for (int i = 0; i < N; i++) begin
            if (owner_r == OW'(i)) begin
                sel_valid_s = req_valid[i];
                sel_data_s  = req_data[8*i +: 8];
                sel_addr_s  = req_addr[32*i +: 32];
            end else begin
                sel_valid_s = sel_valid_s;
            end
        end
    end

    // Ready is a pure function of registered state so it never loops through req_valid.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N; i++) begin
            if ((state_r == ST_LOCKED) && (owner_r == OW'(i))) begin
                req_ready[i] = 1'b1;
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    // Transfer and release conditions for the locked owner.
    always_comb begin
        xfer_s     = (state_r == ST_LOCKED) && sel_valid_s;
        lf_hit_s   = (sel_data_s == ASCII_LF);
        cap_hit_s  = (char_cnt_r >= CHAR_LAST);
        idle_hit_s = (idle_cnt_r >= IDLE_LAST);
    end

`ifdef UART_ARB_LINE_TAG_EN
    // Tag bytes "[", owner digit, "]", " " emitted one per prefix state.
    always_comb begin
        pfx_valid_s = 1'b1;
        pfx_data_s  = 8'h00;
        case (state_r)
            ST_PFX0: pfx_data_s = ASCII_LBR;
            ST_PFX1: pfx_data_s = ASCII_ZERO + 8'(owner_r);
            ST_PFX2: pfx_data_s = ASCII_RBR;
            ST_PFX3: pfx_data_s = ASCII_SP;
            default: begin
                pfx_valid_s = 1'b0;
                pfx_data_s  = 8'h00;
            end
        endcase
    end
`else
    // No line tag: prefix path is inert.
    always_comb begin
        pfx_valid_s = 1'b0;
        pfx_data_s  = 8'h00;
    end
`endif

    // FSM next-state, owner and counter update.
    always_comb begin
        state_nxt_s    = state_r;
        owner_nxt_s    = owner_r;
        char_cnt_nxt_s = char_cnt_r;
        idle_cnt_nxt_s = idle_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (any_valid_s) begin
                    owner_nxt_s    = pick_s;
`ifdef UART_ARB_LINE_TAG_EN
                    state_nxt_s    = ST_PFX0;
`else
                    state_nxt_s    = ST_LOCKED;
`endif
                    char_cnt_nxt_s = '0;
                    idle_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
`ifdef UART_ARB_LINE_TAG_EN
            ST_PFX0: state_nxt_s = ST_PFX1;
            ST_PFX1: state_nxt_s = ST_PFX2;
            ST_PFX2: state_nxt_s = ST_PFX3;
            ST_PFX3: begin
                state_nxt_s    = ST_LOCKED;
                char_cnt_nxt_s = '0;
                idle_cnt_nxt_s = '0;
            end
`endif
            ST_LOCKED: begin
                if (xfer_s) begin
                    idle_cnt_nxt_s = '0;
                    if (char_cnt_r == CHAR_MAX) begin
                        char_cnt_nxt_s = char_cnt_r;
                    end else begin
                        char_cnt_nxt_s = char_cnt_r + CW'(1);
                    end
                    if (lf_hit_s || cap_hit_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_LOCKED;
                    end
                end else if (idle_hit_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    idle_cnt_nxt_s = idle_cnt_r + IW'(1);
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output byte: accepted character takes priority over the tag path.
    always_comb begin
        out_valid_nxt_s = xfer_s || pfx_valid_s;
        if (xfer_s) begin
            out_data_nxt_s = sel_data_s;
        end else begin
            out_data_nxt_s = pfx_data_s;
        end
    end

    // State and output registers; reset abandons any line in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            owner_r     <= OW'(N - 1);
            char_cnt_r  <= '0;
            idle_cnt_r  <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            out_addr_r  <= 32'h0000_0000;
        end else begin
            state_r     <= state_nxt_s;
            owner_r     <= owner_nxt_s;
            char_cnt_r  <= char_cnt_nxt_s;
            idle_cnt_r  <= idle_cnt_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_addr_r  <= sel_addr_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_addr  = out_addr_r;
    assign owner     = owner_r;
    assign busy      = (state_r != ST_IDLE);

endmodule
